// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: handshake and data bundle of the iterative multiply/divide unit.
//   start_i/op_i/data1_i/data2_i : operation request (accepted while busy_o=0)
//   wr_hi_i/wr_lo_i/wr_data_i    : direct HI/LO writes (MTHI/MTLO)
//   busy_o/done_o/div_zero_o     : status; done_o pulses when an op updates HI/LO
//   hi_o/lo_o                    : architectural HI/LO registers
// master = control unit side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             wr_hi_i;
  logic             wr_lo_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, data1_i, data2_i, wr_hi_i, wr_lo_i, wr_data_i,
    input  busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, data1_i, data2_i, wr_hi_i, wr_lo_i, wr_data_i,
    output busy_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : muldiv_unit_if.slave (request, direct writes, status, HI/LO)
// Operands are reduced to magnitudes on acceptance, WIDTH unsigned steps run
// in CALC, and FIX applies the sign correction and writes HI/LO. Latency from
// the accepting edge to done_o is WIDTH+1 cycles for every op.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_res;   // product / quotient must be negated
  logic               r_neg_rem;   // remainder takes dividend sign
  logic [WIDTH-1:0]   r_opb;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;       // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done, r_dz;

  logic               w_accept, w_wr_ok;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_accept = (r_state == S_IDLE) && bus.start_i;
  assign w_wr_ok  = (r_state == S_IDLE) && !bus.start_i;

  // Two's-complement magnitudes; MIN maps onto itself, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign w_a_neg = bus.op_i[0] && bus.data1_i[WIDTH-1];
  assign w_b_neg = bus.op_i[0] && bus.data2_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.data1_i : bus.data1_i;
  assign w_b_mag = w_b_neg ? -bus.data2_i : bus.data2_i;

  // Multiply step: conditionally add multiplicand into upper half, shift right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: remainder < divisor keeps {rem, next bit} within
  // WIDTH+1 bits, so the trial's top bit is the borrow.
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
  assign w_div_nxt   = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction. With a zero divisor the remainder path reproduces the
  // raw dividend (|a| with a's sign), so only LO needs overriding.
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
      if (w_accept) begin
        r_cnt     <= '0;
        r_is_div  <= bus.op_i[1];
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_opb     <= bus.op_i[1] ? w_b_mag : w_a_mag;
        r_acc     <= {{WIDTH{1'b0}}, bus.op_i[1] ? w_a_mag : w_b_mag};
        r_dz      <= bus.op_i[1] && (bus.data2_i == '0);
      end
      if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end
      if (r_state == S_FIX) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= r_dz ? '1 : w_quot;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
      if (w_wr_ok && bus.wr_hi_i) r_hi <= bus.wr_data_i;
      if (w_wr_ok && bus.wr_lo_i) r_lo <= bus.wr_data_i;
    end
  end

  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.div_zero_o = r_dz;
  assign bus.hi_o       = r_hi;
  assign bus.lo_o       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32, rst8;

  muldiv_unit_if #(.WIDTH(32)) b32();
  muldiv_unit_if #(.WIDTH(8))  b8();
  muldiv_unit #(.WIDTH(32), .CNT_W(6)) u32 (.clk_i(clk), .rst_i(rst32), .bus(b32.slave));
  muldiv_unit #(.WIDTH(8),  .CNT_W(4)) u8  (.clk_i(clk), .rst_i(rst8),  .bus(b8.slave));

  int n_chk = 0, n_err = 0;
  bit s8;
  int W;
  logic [31:0] m, mn;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL W%0d %s: got %h expected %h", W, tag, act, exp);
    end
  endtask

  function automatic logic [31:0] f_hi();   return s8 ? {24'h0, b8.hi_o} : b32.hi_o; endfunction
  function automatic logic [31:0] f_lo();   return s8 ? {24'h0, b8.lo_o} : b32.lo_o; endfunction
  function automatic logic [31:0] f_busy(); return s8 ? 32'(b8.busy_o) : 32'(b32.busy_o); endfunction
  function automatic logic [31:0] f_done(); return s8 ? 32'(b8.done_o) : 32'(b32.done_o); endfunction
  function automatic logic [31:0] f_dz();   return s8 ? 32'(b8.div_zero_o) : 32'(b32.div_zero_o); endfunction

  task automatic set_in(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (s8) begin b8.start_i = st; b8.op_i = op; b8.data1_i = a[7:0]; b8.data2_i = b[7:0]; end
    else    begin b32.start_i = st; b32.op_i = op; b32.data1_i = a; b32.data2_i = b; end
  endtask

  task automatic set_wr(input logic wh, input logic wl, input logic [31:0] d);
    if (s8) begin b8.wr_hi_i = wh; b8.wr_lo_i = wl; b8.wr_data_i = d[7:0]; end
    else    begin b32.wr_hi_i = wh; b32.wr_lo_i = wl; b32.wr_data_i = d; end
  endtask

  task automatic set_rst(input logic v);
    if (s8) rst8 = v; else rst32 = v;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Drive start for one edge; returns one step after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    set_in(1'b1, op, a, b);
    cyc();
    set_in(1'b0, op, a, b);
    chk("busy_on", f_busy(), 1);
  endtask

  // n0 = cycles already elapsed since the accepting edge. Ends in the done cycle.
  task automatic wait_done(input string tag, input int n0);
    int n = n0, bc = n0;
    logic hold = 1'b1;
    logic [31:0] h0 = f_hi(), l0 = f_lo();
    while (f_done() == 0 && n < 100) begin
      if (f_busy() != 0) bc++;
      if (f_hi() !== h0 || f_lo() !== l0) hold = 1'b0;
      cyc();
      n++;
    end
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_busycyc"}, bc, W + 1);
    chk({tag, "_busyoff"}, f_busy(), 0);
    chk({tag, "_hold"}, 32'(hold), 1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic [31:0] edz);
    start_op(op, a, b);
    wait_done(tag, 0);
    chk({tag, "_hi"}, f_hi(), eh & m);
    chk({tag, "_lo"}, f_lo(), el & m);
    chk({tag, "_dz"}, f_dz(), edz);
    cyc();
    chk({tag, "_pulse"}, f_done(), 0);
  endtask

  task automatic suite();
    int seen;
    set_in(1'b0, OP_MULTU, 0, 0);
    set_wr(1'b0, 1'b0, 0);
    set_rst(1'b0);
    cyc(); cyc();
    chk("rst_hi", f_hi(), 0);   chk("rst_lo", f_lo(), 0);
    chk("rst_busy", f_busy(), 0); chk("rst_done", f_done(), 0); chk("rst_dz", f_dz(), 0);
    @(negedge clk); set_rst(1'b1);
    cyc();

    run("multu_max", OP_MULTU, m, m, m - 1, 1, 0);
    run("mult_neg",  OP_MULT, -32'sd3, 5, 32'hFFFFFFFF, -32'sd15, 0);
    run("div_neg",   OP_DIV, -32'sd7, 2, 32'hFFFFFFFF, -32'sd3, 0);
    run("divu",      OP_DIVU, 7, 2, 1, 3, 0);
    run("div_ovf",   OP_DIV, mn, m, 0, mn, 0);
    run("divu_zero", OP_DIVU, 32'h1234, 0, 32'h1234, 32'hFFFFFFFF, 1);
    run("div_zero",  OP_DIV, -32'sd5, 0, -32'sd5, 32'hFFFFFFFF, 1);
    run("multu_67",  OP_MULTU, 6, 7, 0, 42, 0);
    run("mult_min",  OP_MULT, mn, mn, mn >> 1, 0, 0);

    // start while busy is ignored
    start_op(OP_MULTU, 3, 4);
    repeat (5) cyc();
    set_in(1'b1, OP_MULTU, 9, 9);
    cyc();
    set_in(1'b0, OP_MULTU, 0, 0);
    wait_done("ign", 6);
    chk("ign_hi", f_hi(), 0); chk("ign_lo", f_lo(), 12);
    seen = 0;
    repeat (W + 4) begin cyc(); if (f_done() != 0) seen++; end
    chk("ign_nosecond", seen, 0); chk("ign_lo2", f_lo(), 12);

    // start in the done cycle is accepted
    start_op(OP_MULTU, 5, 5);
    wait_done("b2b_a", 0);
    chk("b2b_a_lo", f_lo(), 25);
    start_op(OP_MULTU, 2, 3);
    wait_done("b2b_b", 0);
    chk("b2b_b_lo", f_lo(), 6);
    cyc();

    // direct writes in IDLE
    set_wr(1'b1, 1'b0, 32'hA5A5A5A5);
    cyc();
    set_wr(1'b0, 1'b0, 0);
    chk("mthi_hi", f_hi(), 32'hA5A5A5A5 & m); chk("mthi_lo", f_lo(), 6); chk("mthi_done", f_done(), 0);
    set_wr(1'b1, 1'b1, 32'h0F0F0F0F);
    cyc();
    set_wr(1'b0, 1'b0, 0);
    chk("both_hi", f_hi(), 32'h0F0F0F0F & m); chk("both_lo", f_lo(), 32'h0F0F0F0F & m);

    // writes during busy are ignored
    start_op(OP_MULTU, 1, 1);
    set_wr(1'b1, 1'b1, 32'h12345678);
    cyc(); cyc();
    set_wr(1'b0, 1'b0, 0);
    chk("bwr_hi", f_hi(), 32'h0F0F0F0F & m); chk("bwr_lo", f_lo(), 32'h0F0F0F0F & m);
    wait_done("bwr", 2);
    chk("bwr_res_hi", f_hi(), 0); chk("bwr_res_lo", f_lo(), 1);
    cyc();

    // start wins over a same-edge write
    set_in(1'b1, OP_MULTU, 2, 2);
    set_wr(1'b0, 1'b1, 32'hDEAD);
    cyc();
    set_in(1'b0, OP_MULTU, 0, 0);
    set_wr(1'b0, 1'b0, 0);
    chk("swin_lo", f_lo(), 1); chk("swin_busy", f_busy(), 1);
    wait_done("swin", 0);
    chk("swin_res_lo", f_lo(), 4);
    cyc();

    // reset mid-divide
    run("pre_rst", OP_MULT, -32'sd3, 5, 32'hFFFFFFFF, -32'sd15, 0);
    start_op(OP_DIV, 100, 7);
    repeat (9) cyc();
    set_rst(1'b0);
    #1;
    chk("arst_busy", f_busy(), 0); chk("arst_done", f_done(), 0);
    chk("arst_hi", f_hi(), 0);     chk("arst_lo", f_lo(), 0);
    @(negedge clk); set_rst(1'b1);
    cyc();
    run("post_rst", OP_MULTU, 6, 7, 0, 42, 0);
  endtask

  initial begin
    rst32 = 1'b0; rst8 = 1'b0;
    b32.start_i = 0; b32.op_i = 0; b32.data1_i = 0; b32.data2_i = 0;
    b32.wr_hi_i = 0; b32.wr_lo_i = 0; b32.wr_data_i = 0;
    b8.start_i = 0;  b8.op_i = 0;  b8.data1_i = 0;  b8.data2_i = 0;
    b8.wr_hi_i = 0;  b8.wr_lo_i = 0;  b8.wr_data_i = 0;
    s8 = 1'b0; W = 32; m = 32'hFFFFFFFF; mn = 32'h80000000;
    suite();
    s8 = 1'b1; W = 8;  m = 32'h000000FF; mn = 32'h00000080;
    suite();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage of the next-generation core.
- Adds MIPS MULT/MULTU/DIV/DIVU with a start/busy/done handshake, plus direct HI/LO writes (MTHI/MTLO).
- Width is generic; the control unit stalls on busy_o.

Parameters:
WIDTH  32  operand, HI and LO width in bits (even, >=4)
CNT_W  6   iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i       in   1      clock, rising edge
rst_i       in   1      reset, asynchronous, active-low
start_i     in   1      begin operation; sampled only when busy_o=0
op_i        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
data1_i     in   WIDTH  multiplicand / dividend (rs)
data2_i     in   WIDTH  multiplier / divisor (rt)
wr_hi_i     in   1      write HI from wr_data_i (MTHI)
wr_lo_i     in   1      write LO from wr_data_i (MTLO)
wr_data_i   in   WIDTH  HI/LO write data
busy_o      out  1      operation in progress
done_o      out  1      one-cycle pulse: HI/LO just updated by an operation
div_zero_o  out  1      last accepted DIV/DIVU had divisor 0
hi_o        out  WIDTH  HI register
lo_o        out  WIDTH  LO register

Behaviour:
- Reset (rst_i=0, async): state IDLE; hi_o=0, lo_o=0; busy_o=0, done_o=0, div_zero_o=0; counter and work regs cleared. Reset mid-operation aborts; HI/LO return 0.
- FSM states IDLE, CALC, FIX. All outputs are registered.
- IDLE: start_i=1 at edge E0 latches op, operand magnitudes (signed ops: two's-complement abs), sign flags, counter=0 -> CALC; busy_o=1 after E0. div_zero_o updates at E0: 1 if op is DIV/DIVU and data2_i=0, else 0.
- CALC: one radix-2 step per edge, at edges E1..E_WIDTH.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient bit per step.
  - counter==WIDTH-1 at a CALC edge -> FIX.
- FIX (edge E_WIDTH+1): sign correction, HI/LO written, done_o=1 and busy_o=0 for the following cycle -> IDLE. Latency start edge to done_o = WIDTH+1 cycles, independent of operands and op.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product. MULT negates when operand signs differ.
  - Divide: lo = quotient, hi = remainder. DIV: quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
  - DIV MIN / -1: lo = MIN (wraps), hi = 0; no flag.
  - Divide by zero: full latency still taken; hi = data1_i as latched, lo = all ones; div_zero_o=1. Applies to signed and unsigned.
- start_i while busy_o=1: ignored, no queuing, in-flight operation unaffected.
- start_i in the done_o cycle: accepted (busy_o is 0); back-to-back throughput is one op per WIDTH+2 cycles.
- wr_hi_i/wr_lo_i:
  - Honoured only in IDLE with start_i=0; written at that edge, visible next cycle; done_o not asserted.
  - Both may be asserted together.
  - Ignored while busy_o=1, and ignored when start_i is accepted on the same edge (start wins).
- done_o is exactly one cycle and never asserted for direct writes.
- hi_o/lo_o hold their values throughout CALC; intermediate values are never exposed.

Test Plan:
- WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy_o high for 33 cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7 / 2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero_o=0. DIVU 0x1234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF, div_zero_o=1. The next accepted MULTU clears div_zero_o.
- start_i pulsed with different operands 5 cycles into a MULTU -> first result unchanged, second op not executed. start_i asserted in the done_o cycle -> second op accepted, its done_o 33 cycles later.
- In IDLE: wr_hi_i=1, wr_data_i=0xA5A5A5A5 -> hi=0xA5A5A5A5, lo unchanged, no done_o. The same write during busy -> ignored. wr_lo_i together with an accepted start_i -> write dropped.
- rst_i low 10 cycles into a DIV -> immediately busy_o=0, done_o=0, hi=lo=0. After release, a fresh MULTU 6 x 7 -> lo=42, hi=0.
- Repeat the directed cases at WIDTH=8, CNT_W=4: latency 9 cycles; MULT 0x80 x 0x80 -> hi=0x40, lo=0x00.
